// File: rtl/bpd_update_pkg.sv
// Shared types and constants for the branch-predictor update serializer.
// Optional feature macro used by the top: BPD_UPDATE_PERF_EN.
package bpd_update_pkg;

    localparam int BPD_PC_W       = 40;
    localparam int BPD_HIST_W     = 64;
    localparam int BPD_META_W     = 120;
    localparam int BPD_BANK_BYTES = 8;
    localparam int BANK_SLOTS     = 4;
    localparam int FETCH_SLOTS    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } state_t;

    // Whole fetch-packet update as it leaves the update queue.
    typedef struct packed {
        logic                      is_mispredict_update;
        logic                      is_repair_update;
        logic [FETCH_SLOTS-1:0]    btb_mispredicts;
        logic [BPD_PC_W-1:0]       pc;
        logic [FETCH_SLOTS-1:0]    br_mask;
        logic                      cfi_idx_valid;
        logic [2:0]                cfi_idx_bits;
        logic                      cfi_taken;
        logic                      cfi_mispredicted;
        logic                      cfi_is_br;
        logic                      cfi_is_jal;
        logic [BPD_HIST_W-1:0]     ghist;
        logic                      ghist_saw_nt;
        logic                      ghist_saw_t;
        logic [BPD_PC_W-1:0]       target;
        logic [BPD_META_W-1:0]     meta_0;
        logic [BPD_META_W-1:0]     meta_1;
    } update_bundle_t;

    // One bank's worth of the update, as presented to the predictor port.
    typedef struct packed {
        logic                      bank;
        logic [BPD_PC_W-1:0]       pc;
        logic [BANK_SLOTS-1:0]     br_mask;
        logic [BANK_SLOTS-1:0]     btb_mispredicts;
        logic                      cfi_valid;
        logic [1:0]                cfi_idx;
        logic                      cfi_taken;
        logic                      cfi_mispredicted;
        logic                      cfi_is_br;
        logic                      cfi_is_jal;
        logic                      is_mispredict_update;
        logic                      is_repair_update;
        logic [BPD_HIST_W-1:0]     ghist;
        logic                      ghist_saw_nt;
        logic                      ghist_saw_t;
        logic [BPD_PC_W-1:0]       target;
        logic [BPD_META_W-1:0]     meta;
    } bank_update_t;

    // A bank needs an update if it has anything to train, or on any repair.
    function automatic logic bank_needed(input update_bundle_t b, input logic bank);
        logic [BANK_SLOTS-1:0] brs;
        logic [BANK_SLOTS-1:0] btbs;
        brs  = bank ? b.br_mask[BANK_SLOTS +: BANK_SLOTS] : b.br_mask[0 +: BANK_SLOTS];
        btbs = bank ? b.btb_mispredicts[BANK_SLOTS +: BANK_SLOTS]
                    : b.btb_mispredicts[0 +: BANK_SLOTS];
        return b.is_repair_update | (|brs) | (|btbs)
             | (b.cfi_idx_valid & (b.cfi_idx_bits[2] == bank));
    endfunction

endpackage

// File: rtl/bpd_bank_slice.sv
// Combinational extraction of one bank's update from a held fetch-packet update.
module bpd_bank_slice
    import bpd_update_pkg::*;
(
    input  update_bundle_t bundle,
    input  logic           bank,
    output bank_update_t   upd
);

    logic [BPD_PC_W-1:0] base_pc;
    logic                cfi_here;

    // Align the PC to the bank pair, remap CFI into the bank, pick the bank's slice.
    always_comb begin
        base_pc  = bundle.pc & ~BPD_PC_W'(2 * BPD_BANK_BYTES - 1);
        cfi_here = bundle.cfi_idx_valid & (bundle.cfi_idx_bits[2] == bank);
        upd      = '0;

        upd.bank                 = bank;
        upd.pc                   = bank ? base_pc + BPD_PC_W'(BPD_BANK_BYTES) : base_pc;
        upd.br_mask              = bank ? bundle.br_mask[BANK_SLOTS +: BANK_SLOTS]
                                        : bundle.br_mask[0 +: BANK_SLOTS];
        upd.btb_mispredicts      = bank ? bundle.btb_mispredicts[BANK_SLOTS +: BANK_SLOTS]
                                        : bundle.btb_mispredicts[0 +: BANK_SLOTS];
        upd.cfi_valid            = cfi_here;
        upd.cfi_idx              = bundle.cfi_idx_bits[1:0];
        upd.cfi_taken            = cfi_here & bundle.cfi_taken;
        upd.cfi_mispredicted     = cfi_here & bundle.cfi_mispredicted;
        upd.cfi_is_br            = cfi_here & bundle.cfi_is_br;
        upd.cfi_is_jal           = cfi_here & bundle.cfi_is_jal;
        upd.is_mispredict_update = bundle.is_mispredict_update;
        upd.is_repair_update     = bundle.is_repair_update;
        upd.ghist                = bundle.ghist;
        upd.ghist_saw_nt         = bundle.ghist_saw_nt;
        upd.ghist_saw_t          = bundle.ghist_saw_t;
        upd.target               = bundle.target;
        upd.meta                 = bank ? bundle.meta_1 : bundle.meta_0;
    end

endmodule

// File: rtl/bpd_update_serializer.sv
// Splits each fetch-packet predictor update into bank-0 / bank-1 updates for a
// single-ported two-bank update port. Empty banks are skipped, empty bundles dropped.
// Optional macro BPD_UPDATE_PERF_EN adds wrapping event counters.
module bpd_update_serializer
    import bpd_update_pkg::*;
#(
    parameter int PC_W       = BPD_PC_W,
    parameter int HIST_W     = BPD_HIST_W,
    parameter int META_W     = BPD_META_W,
    parameter int BANK_BYTES = BPD_BANK_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_is_mispredict_update,
    input  logic              in_is_repair_update,
    input  logic [7:0]        in_btb_mispredicts,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [7:0]        in_br_mask,
    input  logic              in_cfi_idx_valid,
    input  logic [2:0]        in_cfi_idx_bits,
    input  logic              in_cfi_taken,
    input  logic              in_cfi_mispredicted,
    input  logic              in_cfi_is_br,
    input  logic              in_cfi_is_jal,
    input  logic [HIST_W-1:0] in_ghist_old_history,
    input  logic              in_ghist_new_saw_branch_not_taken,
    input  logic              in_ghist_new_saw_branch_taken,
    input  logic [PC_W-1:0]   in_target,
    input  logic [META_W-1:0] in_meta_0,
    input  logic [META_W-1:0] in_meta_1,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bank,
    output logic [PC_W-1:0]   out_pc,
    output logic [3:0]        out_br_mask,
    output logic [3:0]        out_btb_mispredicts,
    output logic              out_cfi_valid,
    output logic [1:0]        out_cfi_idx,
    output logic              out_cfi_taken,
    output logic              out_cfi_mispredicted,
    output logic              out_cfi_is_br,
    output logic              out_cfi_is_jal,
    output logic              out_is_mispredict_update,
    output logic              out_is_repair_update,
    output logic [HIST_W-1:0] out_ghist,
    output logic              out_ghist_saw_nt,
    output logic              out_ghist_saw_t,
    output logic [PC_W-1:0]   out_target,
    output logic [META_W-1:0] out_meta
`ifdef BPD_UPDATE_PERF_EN
    ,
    output logic [31:0]       perf_bundles,
    output logic [31:0]       perf_bank_updates,
    output logic [31:0]       perf_dropped,
    output logic [31:0]       perf_stall_cycles
`endif
);

    state_t         state, state_next;
    update_bundle_t held, incoming;
    logic           need1_q;
    logic           need0_in, need1_in;
    logic           accept;
    bank_update_t   slice, shown;

    // Gather the dequeue bundle into one record.
    always_comb begin
        incoming                      = '0;
        incoming.is_mispredict_update = in_is_mispredict_update;
        incoming.is_repair_update     = in_is_repair_update;
        incoming.btb_mispredicts      = in_btb_mispredicts;
        incoming.pc                   = in_pc;
        incoming.br_mask              = in_br_mask;
        incoming.cfi_idx_valid        = in_cfi_idx_valid;
        incoming.cfi_idx_bits         = in_cfi_idx_bits;
        incoming.cfi_taken            = in_cfi_taken;
        incoming.cfi_mispredicted     = in_cfi_mispredicted;
        incoming.cfi_is_br            = in_cfi_is_br;
        incoming.cfi_is_jal           = in_cfi_is_jal;
        incoming.ghist                = in_ghist_old_history;
        incoming.ghist_saw_nt         = in_ghist_new_saw_branch_not_taken;
        incoming.ghist_saw_t          = in_ghist_new_saw_branch_taken;
        incoming.target               = in_target;
        incoming.meta_0               = in_meta_0;
        incoming.meta_1               = in_meta_1;
    end

    assign need0_in = bank_needed(incoming, 1'b0);
    assign need1_in = bank_needed(incoming, 1'b1);
    assign accept   = in_valid & in_ready;

    // Handshake and next state; a new bundle may be taken in the last emit cycle.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT0: begin
                out_valid = 1'b1;
                in_ready  = out_ready & ~need1_q;
                if (out_ready) state_next = need1_q ? EMIT1 : IDLE;
            end
            EMIT1: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (in_valid && in_ready) begin
            state_next = need0_in ? EMIT0 : (need1_in ? EMIT1 : IDLE);
        end
    end

    // State and held bundle; reset discards any half-emitted bundle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            held    <= '0;
            need1_q <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                held    <= incoming;
                need1_q <= need1_in;
            end
        end
    end

    bpd_bank_slice u_slice (
        .bundle (held),
        .bank   (state == EMIT1),
        .upd    (slice)
    );

    // Outputs read zero whenever nothing is being presented.
    always_comb begin
        shown = out_valid ? slice : '0;
    end

    assign out_bank                 = shown.bank;
    assign out_pc                   = shown.pc;
    assign out_br_mask              = shown.br_mask;
    assign out_btb_mispredicts      = shown.btb_mispredicts;
    assign out_cfi_valid            = shown.cfi_valid;
    assign out_cfi_idx              = shown.cfi_idx;
    assign out_cfi_taken            = shown.cfi_taken;
    assign out_cfi_mispredicted     = shown.cfi_mispredicted;
    assign out_cfi_is_br            = shown.cfi_is_br;
    assign out_cfi_is_jal           = shown.cfi_is_jal;
    assign out_is_mispredict_update = shown.is_mispredict_update;
    assign out_is_repair_update     = shown.is_repair_update;
    assign out_ghist                = shown.ghist;
    assign out_ghist_saw_nt         = shown.ghist_saw_nt;
    assign out_ghist_saw_t          = shown.ghist_saw_t;
    assign out_target               = shown.target;
    assign out_meta                 = shown.meta;

`ifdef BPD_UPDATE_PERF_EN
    // Event counters: accepts, bank fires, dropped bundles, backpressured cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            perf_bundles      <= '0;
            perf_bank_updates <= '0;
            perf_dropped      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (accept)                         perf_bundles      <= perf_bundles + 32'd1;
            if (out_valid & out_ready)          perf_bank_updates <= perf_bank_updates + 32'd1;
            if (accept & ~need0_in & ~need1_in) perf_dropped      <= perf_dropped + 32'd1;
            if (out_valid & ~out_ready)         perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bpd_update_serializer.sv
// Bench for bpd_update_serializer: directed steps plus randomized bundles with a
// queue-based reference model. Perf counter checks compile in with BPD_UPDATE_PERF_EN.
module tb_bpd_update_serializer;

    localparam int PC_W   = 40;
    localparam int HIST_W = 64;
    localparam int META_W = 120;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid, in_ready;
    logic              in_is_mispredict_update, in_is_repair_update;
    logic [7:0]        in_btb_mispredicts, in_br_mask;
    logic [PC_W-1:0]   in_pc, in_target;
    logic              in_cfi_idx_valid;
    logic [2:0]        in_cfi_idx_bits;
    logic              in_cfi_taken, in_cfi_mispredicted, in_cfi_is_br, in_cfi_is_jal;
    logic [HIST_W-1:0] in_ghist_old_history;
    logic              in_ghist_new_saw_branch_not_taken, in_ghist_new_saw_branch_taken;
    logic [META_W-1:0] in_meta_0, in_meta_1;
    logic              out_valid, out_ready, out_bank;
    logic [PC_W-1:0]   out_pc, out_target;
    logic [3:0]        out_br_mask, out_btb_mispredicts;
    logic              out_cfi_valid;
    logic [1:0]        out_cfi_idx;
    logic              out_cfi_taken, out_cfi_mispredicted, out_cfi_is_br, out_cfi_is_jal;
    logic              out_is_mispredict_update, out_is_repair_update;
    logic [HIST_W-1:0] out_ghist;
    logic              out_ghist_saw_nt, out_ghist_saw_t;
    logic [META_W-1:0] out_meta;
`ifdef BPD_UPDATE_PERF_EN
    logic [31:0]       perf_bundles, perf_bank_updates, perf_dropped, perf_stall_cycles;
    logic [31:0]       snap_a, snap_b;
`endif

    bpd_update_serializer dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_is_mispredict_update(in_is_mispredict_update),
        .in_is_repair_update(in_is_repair_update),
        .in_btb_mispredicts(in_btb_mispredicts), .in_pc(in_pc), .in_br_mask(in_br_mask),
        .in_cfi_idx_valid(in_cfi_idx_valid), .in_cfi_idx_bits(in_cfi_idx_bits),
        .in_cfi_taken(in_cfi_taken), .in_cfi_mispredicted(in_cfi_mispredicted),
        .in_cfi_is_br(in_cfi_is_br), .in_cfi_is_jal(in_cfi_is_jal),
        .in_ghist_old_history(in_ghist_old_history),
        .in_ghist_new_saw_branch_not_taken(in_ghist_new_saw_branch_not_taken),
        .in_ghist_new_saw_branch_taken(in_ghist_new_saw_branch_taken),
        .in_target(in_target), .in_meta_0(in_meta_0), .in_meta_1(in_meta_1),
        .out_valid(out_valid), .out_ready(out_ready), .out_bank(out_bank), .out_pc(out_pc),
        .out_br_mask(out_br_mask), .out_btb_mispredicts(out_btb_mispredicts),
        .out_cfi_valid(out_cfi_valid), .out_cfi_idx(out_cfi_idx),
        .out_cfi_taken(out_cfi_taken), .out_cfi_mispredicted(out_cfi_mispredicted),
        .out_cfi_is_br(out_cfi_is_br), .out_cfi_is_jal(out_cfi_is_jal),
        .out_is_mispredict_update(out_is_mispredict_update),
        .out_is_repair_update(out_is_repair_update),
        .out_ghist(out_ghist), .out_ghist_saw_nt(out_ghist_saw_nt),
        .out_ghist_saw_t(out_ghist_saw_t), .out_target(out_target),
`ifdef BPD_UPDATE_PERF_EN
        .perf_bundles(perf_bundles), .perf_bank_updates(perf_bank_updates),
        .perf_dropped(perf_dropped), .perf_stall_cycles(perf_stall_cycles),
`endif
        .out_meta(out_meta)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic              mp, rep;
        logic [7:0]        btb, brm;
        logic [PC_W-1:0]   pc, target;
        logic              cv;
        logic [2:0]        cbits;
        logic              taken, mis, isbr, isjal;
        logic [HIST_W-1:0] ghist;
        logic              snt, st;
        logic [META_W-1:0] meta0, meta1;
    } bundle_t;

    typedef struct {
        logic              bank;
        logic [PC_W-1:0]   pc;
        logic [3:0]        brm, btb;
        logic              cv;
        logic [1:0]        ci;
        logic [3:0]        attrs;
        logic [1:0]        kinds;
        logic [HIST_W-1:0] ghist;
        logic [1:0]        flags;
        logic [PC_W-1:0]   target;
        logic [META_W-1:0] meta;
    } exp_t;

    exp_t    exp_q[$];
    int      checks = 0;
    int      errors = 0;
    int      cyc = 0;
    bit      rand_ready = 1'b0;
    bundle_t b;
    int      c1, c2;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a bundle becomes 0, 1 or 2 bank updates, bank 0 first.
    function automatic void model_push(input bundle_t x);
        logic [PC_W-1:0] base;
        exp_t            e;
        bit              need;
        base = (x.pc >> 4) << 4;
        for (int k = 0; k < 2; k++) begin
            need = x.rep || (((x.brm >> (4 * k)) & 8'hF) != 8'h0)
                         || (((x.btb >> (4 * k)) & 8'hF) != 8'h0)
                         || (x.cv && (int'(x.cbits) / 4 == k));
            if (need) begin
                e.bank   = (k == 1);
                e.pc     = base + PC_W'(8 * k);
                e.brm    = 4'((x.brm >> (4 * k)) & 8'hF);
                e.btb    = 4'((x.btb >> (4 * k)) & 8'hF);
                e.cv     = x.cv && (int'(x.cbits) / 4 == k);
                e.ci     = 2'(int'(x.cbits) % 4);
                e.attrs  = e.cv ? {x.taken, x.mis, x.isbr, x.isjal} : 4'h0;
                e.kinds  = {x.mp, x.rep};
                e.ghist  = x.ghist;
                e.flags  = {x.snt, x.st};
                e.target = x.target;
                e.meta   = (k == 1) ? x.meta1 : x.meta0;
                exp_q.push_back(e);
            end
        end
    endfunction

    // Scoreboard: every bank update that fires must match the model's next entry.
    always @(negedge clock) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chkw("spurious_out_valid", 128'(out_valid), 128'(0));
            end else begin
                e = exp_q.pop_front();
                chkw("sb_bank",   128'(out_bank), 128'(e.bank));
                chkw("sb_pc",     128'(out_pc), 128'(e.pc));
                chkw("sb_masks",  128'({out_br_mask, out_btb_mispredicts}), 128'({e.brm, e.btb}));
                chkw("sb_cfi",    128'({out_cfi_valid, out_cfi_idx, out_cfi_taken, out_cfi_mispredicted,
                                        out_cfi_is_br, out_cfi_is_jal}), 128'({e.cv, e.ci, e.attrs}));
                chkw("sb_kinds",  128'({out_is_mispredict_update, out_is_repair_update}), 128'(e.kinds));
                chkw("sb_ghist",  128'({out_ghist, out_ghist_saw_nt, out_ghist_saw_t}), 128'({e.ghist, e.flags}));
                chkw("sb_target", 128'(out_target), 128'(e.target));
                chkw("sb_meta",   128'(out_meta), 128'(e.meta));
            end
        end
    end

    task automatic apply(input bundle_t x);
        in_is_mispredict_update = x.mp;    in_is_repair_update = x.rep;
        in_btb_mispredicts = x.btb;        in_br_mask = x.brm;
        in_pc = x.pc;                      in_target = x.target;
        in_cfi_idx_valid = x.cv;           in_cfi_idx_bits = x.cbits;
        in_cfi_taken = x.taken;            in_cfi_mispredicted = x.mis;
        in_cfi_is_br = x.isbr;             in_cfi_is_jal = x.isjal;
        in_ghist_old_history = x.ghist;
        in_ghist_new_saw_branch_not_taken = x.snt;
        in_ghist_new_saw_branch_taken = x.st;
        in_meta_0 = x.meta0;               in_meta_1 = x.meta1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic send(input bundle_t x, output int acc_cyc);
        int n;
        n = 0;
        apply(x);
        in_valid = 1'b1;
        @(negedge clock);
        while (!in_ready && n < 40) begin
            tick();
            @(negedge clock);
            n++;
        end
        chkw("accept_in_ready", 128'(in_ready), 128'(1));
        model_push(x);
        acc_cyc = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    function automatic bundle_t zero_bundle();
        bundle_t z;
        z = '{default: '0};
        z.ghist  = 64'hDEAD_BEEF_0123_4567;
        z.target = 40'h12_3456_7890;
        z.meta0  = {30{4'hA}};
        z.meta1  = {30{4'h5}};
        return z;
    endfunction

    function automatic bundle_t rand_bundle();
        bundle_t r;
        r.mp     = 1'($urandom_range(0, 1));
        r.rep    = ($urandom_range(0, 7) == 0);
        r.btb    = 8'($urandom) & 8'($urandom) & 8'($urandom) & 8'($urandom);
        r.brm    = 8'($urandom) & 8'($urandom) & 8'($urandom);
        r.pc     = ($urandom_range(0, 9) == 0) ? {PC_W{1'b1}} : PC_W'({$urandom, $urandom});
        r.target = PC_W'({$urandom, $urandom});
        r.cv     = ($urandom_range(0, 2) == 0);
        r.cbits  = 3'($urandom);
        r.taken  = 1'($urandom);  r.mis  = 1'($urandom);
        r.isbr   = 1'($urandom);  r.isjal = 1'($urandom);
        r.ghist  = {$urandom, $urandom};
        r.snt    = 1'($urandom);  r.st = 1'($urandom);
        r.meta0  = META_W'({$urandom, $urandom, $urandom, $urandom});
        r.meta1  = META_W'({$urandom, $urandom, $urandom, $urandom});
        return r;
    endfunction

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        apply(zero_bundle());
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;

        // Reset state
        @(negedge clock);
        chkw("rst_out_valid", 128'(out_valid), 128'(0));
        chkw("rst_in_ready",  128'(in_ready), 128'(1));
        chkw("rst_out_pc",    128'(out_pc), 128'(0));
        chkw("rst_out_meta",  128'(out_meta), 128'(0));
`ifdef BPD_UPDATE_PERF_EN
        chkw("rst_perf", 128'({perf_bundles, perf_bank_updates, perf_dropped, perf_stall_cycles}), 128'(0));
`endif
        tick();

        // Two-bank bundle, then a bank-1-only bundle accepted back-to-back
        out_ready = 1'b1;
        b = zero_bundle();
        b.pc = 40'h80001234;
        b.brm = 8'h11;
        send(b, c1);
        @(negedge clock);
        chkw("t1_b0_valid",    128'(out_valid), 128'(1));
        chkw("t1_b0_bank",     128'(out_bank), 128'(0));
        chkw("t1_b0_pc",       128'(out_pc), 128'(40'h80001230));
        chkw("t1_b0_brmask",   128'(out_br_mask), 128'(4'h1));
        chkw("t1_b0_in_ready", 128'(in_ready), 128'(0));
        tick();
        chkw("t1_b1_bank",     128'(out_bank), 128'(1));
        chkw("t1_b1_pc",       128'(out_pc), 128'(40'h80001238));
        chkw("t1_b1_brmask",   128'(out_br_mask), 128'(4'h1));
        chkw("t1_b1_in_ready", 128'(in_ready), 128'(1));
        b = zero_bundle();
        b.pc = 40'h00000040;
        b.brm = 8'h30;
        send(b, c2);
        chkw("t2_accept_gap", 128'(c2 - c1), 128'(2));
        @(negedge clock);
        chkw("t2_valid",    128'(out_valid), 128'(1));
        chkw("t2_bank",     128'(out_bank), 128'(1));
        chkw("t2_brmask",   128'(out_br_mask), 128'(4'h3));
        chkw("t2_in_ready", 128'(in_ready), 128'(1));

        // Empty bundle is dropped
        tick();
`ifdef BPD_UPDATE_PERF_EN
        snap_a = perf_dropped;
`endif
        b = zero_bundle();
        send(b, c1);
        @(negedge clock);
        chkw("t3_no_valid", 128'(out_valid), 128'(0));
`ifdef BPD_UPDATE_PERF_EN
        chkw("t3_perf_dropped", 128'(perf_dropped - snap_a), 128'(1));
`endif

        // CFI in bank 1, slot 2
        tick();
        b = zero_bundle();
        b.brm = 8'h11;
        b.cv = 1'b1;
        b.cbits = 3'b110;
        b.taken = 1'b1;
        send(b, c1);
        @(negedge clock);
        chkw("t4_b0_cfi",    128'({out_bank, out_cfi_valid, out_cfi_taken}), 128'(3'b000));
        tick();
        chkw("t4_b1_cfi",    128'({out_bank, out_cfi_valid, out_cfi_idx, out_cfi_taken}), 128'(5'b11101));
        tick();

        // Backpressure in EMIT0 for 5 cycles
        out_ready = 1'b0;
        b = zero_bundle();
        b.pc = 40'hFF_FFFF_FFFC;
        b.brm = 8'h11;
`ifdef BPD_UPDATE_PERF_EN
        snap_b = perf_stall_cycles;
`endif
        send(b, c1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chkw("t5_stall_valid",    128'(out_valid), 128'(1));
            chkw("t5_stall_in_ready", 128'(in_ready), 128'(0));
            chkw("t5_stall_data",     128'({out_bank, out_pc, out_br_mask}), 128'({1'b0, 40'hFF_FFFF_FFF0, 4'h1}));
            chkw("t5_stall_meta",     128'(out_meta), 128'(b.meta0));
            tick();
        end
`ifdef BPD_UPDATE_PERF_EN
        chkw("t5_perf_stall", 128'(perf_stall_cycles - snap_b), 128'(5));
`endif
        out_ready = 1'b1;
        tick();
        tick();
        chkw("t5_done_queue", 128'(exp_q.size()), 128'(0));

        // Asynchronous reset during EMIT0
        out_ready = 1'b0;
        b = zero_bundle();
        b.brm = 8'h11;
        send(b, c1);
        @(negedge clock);
        chkw("t6_pre_valid", 128'(out_valid), 128'(1));
        reset = 1'b0;
        #1;
        chkw("t6_rst_valid", 128'(out_valid), 128'(0));
        exp_q.delete();
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        @(negedge clock);
        chkw("t6_idle_in_ready", 128'(in_ready), 128'(1));
        chkw("t6_idle_valid",    128'(out_valid), 128'(0));
`ifdef BPD_UPDATE_PERF_EN
        chkw("t6_perf_cleared", 128'(perf_bundles), 128'(0));
`endif
        tick();
        chkw("t6_no_resume", 128'(out_valid), 128'(0));

        // Randomized bundles with random backpressure
`ifdef BPD_UPDATE_PERF_EN
        snap_a = perf_bundles;
`endif
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            send(rand_bundle(), c1);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) tick();
        tick();
        chkw("rand_drain_empty", 128'(exp_q.size()), 128'(0));
        chkw("rand_final_idle",  128'(out_valid), 128'(0));
`ifdef BPD_UPDATE_PERF_EN
        chkw("rand_perf_bundles", 128'(perf_bundles - snap_a), 128'(300));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bpd_update_serializer.md
Name: bpd_update_serializer

Overview:
- Sits directly downstream of the 2-entry branch-predictor update queue, consuming its dequeue bundle.
- Splits each fetch-packet update into per-bank updates for the single-ported, two-bank predictor update port.
- Emits the bank-0 slice, then the bank-1 slice, one per cycle under a valid/ready handshake.
- Skips banks with nothing to train and drops empty bundles.

Parameters:
- PC_W, 40, PC/target width
- HIST_W, 64, global history width
- META_W, 120, per-bank predictor meta width
- BANK_BYTES, 8, bytes covered by one bank (power of two)

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  update bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_is_mispredict_update, in_is_repair_update  in  1 each  update kind
- in_btb_mispredicts  in  8  per-slot BTB mispredict mask
- in_pc  in  PC_W  fetch-packet PC
- in_br_mask  in  8  per-slot branch mask
- in_cfi_idx_valid  in  1  CFI present
- in_cfi_idx_bits  in  3  CFI slot
- in_cfi_taken, in_cfi_mispredicted, in_cfi_is_br, in_cfi_is_jal  in  1 each  CFI attributes
- in_ghist_old_history  in  HIST_W  global history
- in_ghist_new_saw_branch_not_taken, in_ghist_new_saw_branch_taken  in  1 each  history flags
- in_target  in  PC_W  CFI target
- in_meta_0, in_meta_1  in  META_W each  bank meta
- out_valid  out  1  bank update valid
- out_ready  in  1  predictor accepts
- out_bank  out  1  bank index
- out_pc  out  PC_W  bank-aligned PC
- out_br_mask, out_btb_mispredicts  out  4 each  bank slice
- out_cfi_valid  out  1  CFI lies in this bank
- out_cfi_idx  out  2  slot within bank
- out_cfi_taken, out_cfi_mispredicted, out_cfi_is_br, out_cfi_is_jal  out  1 each  CFI attributes
- out_is_mispredict_update, out_is_repair_update  out  1 each  update kind
- out_ghist  out  HIST_W  history
- out_ghist_saw_nt, out_ghist_saw_t  out  1 each  history flags
- out_target  out  PC_W  CFI target
- out_meta  out  META_W  selected bank meta

Behaviour:
- FSM states IDLE, EMIT0, EMIT1. Reset: IDLE, holding register cleared, out_valid=0, all out_* data=0.
- Accept: in_ready = (state==IDLE) | (state==EMIT1 & out_ready) | (state==EMIT0 & out_ready & ~need1).
- On accept, the whole bundle is registered and need0/need1 are computed.
- needB = repair | (br_mask[4B+3:4B]!=0) | (btb_mispredicts[4B+3:4B]!=0) | (cfi_idx_valid & cfi_idx_bits[2]==B).
- Next state on accept: EMIT0 if need0; else EMIT1 if need1; else stay/return IDLE (bundle dropped, no output).
- Latency: accept in cycle N gives out_valid in cycle N+1. No combinational in->out path.
- Throughput: 2 cycles per two-bank bundle, 1 per one-bank bundle, with back-to-back accept in the final emit cycle.
- EMIT0 on out_ready: go to EMIT1 if need1; else take the next bundle or go to IDLE.
- EMIT1 on out_ready: take the next bundle or go to IDLE.
- out_valid=1 in EMIT0/EMIT1. All out_* stay stable while out_valid & ~out_ready.
- out_pc:
  - bank 0: pc & ~(2*BANK_BYTES-1).
  - bank 1: the same aligned value + BANK_BYTES.
  - Arithmetic is PC_W wide; any carry out is dropped.
- out_cfi_valid = cfi_idx_valid & (cfi_idx_bits[2]==out_bank). out_cfi_idx = cfi_idx_bits[1:0]. CFI attribute outputs are gated to 0 when ~out_cfi_valid.
- out_meta = meta_0 in bank 0, meta_1 in bank 1. History, target and kind flags are copied unchanged to both banks.
- Repair update: both banks are always emitted, even with empty masks.
- Asynchronous reset mid-emission discards the held bundle with no partial-bank completion. The first cycle after release is IDLE.

Optional Feature:
- Macro BPD_UPDATE_PERF_EN.
- Defined: adds outputs perf_bundles[31:0], perf_bank_updates[31:0], perf_dropped[31:0], perf_stall_cycles[31:0].
  - perf_bundles counts accepts; perf_bank_updates counts out fires; perf_dropped counts accepted empty bundles.
  - perf_stall_cycles counts cycles with out_valid & ~out_ready.
  - All counters wrap, reset to 0 on reset.
- Undefined: these ports and registers are absent; functional behaviour is identical.

Decomposition:
- Shared package bpd_update_pkg holds:
  - update bundle struct and per-bank update struct;
  - state enum {IDLE, EMIT0, EMIT1};
  - constants BANK_SLOTS=4 and FETCH_SLOTS=8.
- One sub-module, bpd_bank_slice: combinational extraction of a bank slice (masks, CFI remap, PC alignment, meta select) from the held bundle and a bank index.

Test Plan:
- br_mask=8'h11, pc=40'h80001234, out_ready=1 -> bank0 pc 40'h80001230 then bank1 pc 40'h80001238, br_mask 4'h1 each, 2 cycles, next bundle accepted in cycle 2.
- br_mask=8'h30, no CFI -> single update bank=1, out_br_mask=4'h3; in_ready high in its emit cycle.
- br_mask=0, btb_mispredicts=0, cfi_idx_valid=0, repair=0 -> no out_valid; perf_dropped increments by 1 (BPD_UPDATE_PERF_EN).
- cfi_idx_bits=3'b110, cfi_taken=1, masks in both banks -> bank0 out_cfi_valid=0, taken=0; bank1 out_cfi_valid=1, idx=2'b10, taken=1.
- Hold out_ready=0 for 5 cycles in EMIT0 -> outputs stable, in_ready=0, perf_stall_cycles=5; then release -> normal completion.
- Assert reset low during EMIT0 -> out_valid drops immediately; after release state is IDLE and in_ready=1.
